// File: rtl/int4_unpack_fp16.sv
// Packed INT4 word -> FP16 nibble stream, one exact conversion per cycle, LSB nibble first.
// Feeds the b operand of the FP16 multiplier lane; no scaling is applied here.
module int4_unpack_fp16 #(
  parameter int IN_W     = 32,
  parameter int SIGNED_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_data,
  output logic            out_last
);

  localparam int NIB  = IN_W / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state, state_nxt;
  logic [IN_W-1:0] shreg;
  logic            held_last;
  logic [IDXW-1:0] idx;
  logic            accept, xfer, at_end;

  // Exact INT4 -> FP16: magnitudes 1..15 need at most 4 significant bits,
  // so the mantissa is just the bits below the leading one, left-aligned.
  function automatic logic [15:0] conv(input logic [3:0] nib);
    logic       sgn;
    logic [3:0] mag;
    logic [1:0] msb;
    logic [9:0] mant;
    sgn = (SIGNED_W != 0) && nib[3];
    mag = sgn ? (~nib + 4'd1) : nib;
    msb = 2'd0;
    for (int b = 1; b < 4; b++)
      if (mag[b]) msb = 2'(b);
    case (msb)
      2'd3:    mant = {mag[2:0], 7'd0};
      2'd2:    mant = {mag[1:0], 8'd0};
      2'd1:    mant = {mag[0], 9'd0};
      default: mant = 10'd0;
    endcase
    conv = (mag == 4'd0) ? 16'h0000 : {sgn, 5'd15 + {3'd0, msb}, mant};
  endfunction

  assign at_end    = (idx == IDXW'(NIB - 1));
  assign out_valid = (state == EMIT);
  assign xfer      = out_valid & out_ready;
  assign in_ready  = (state == IDLE) | (xfer & at_end);
  assign accept    = in_valid & in_ready;
  assign out_last  = held_last & at_end;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EMIT;
      EMIT:    if (xfer && at_end && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register holds the not-yet-emitted nibbles; out_data is pre-converted
  // one cycle ahead so the output is a clean register.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      held_last <= 1'b0;
      idx       <= '0;
      out_data  <= 16'h0000;
    end else if (accept) begin
      shreg     <= in_data >> 4;
      held_last <= in_last;
      idx       <= '0;
      out_data  <= conv(in_data[3:0]);
    end else if (xfer && !at_end) begin
      shreg     <= shreg >> 4;
      idx       <= idx + 1'b1;
      out_data  <= conv(shreg[3:0]);
    end
  end

endmodule
